// File: rtl/riscv_clk_pkg.sv
// Shared types and constants for the multi-channel clock divider.
//   clk_cfg_t     : per-channel configuration payload {div, en}
//   DIV_W_DEF     : divisor field width of the payload
//   DEFAULT_DIV_C : half-period divisor applied on reset
package riscv_clk_pkg;

   localparam int unsigned DIV_W_DEF     = 8;
   localparam int unsigned DEFAULT_DIV_C = 3;

   typedef struct packed {
      logic [DIV_W_DEF-1:0] div;
      logic                 en;
   } clk_cfg_t;

endpackage : riscv_clk_pkg

// File: rtl/riscv_clk_div_multi_if.sv
// Config write port between the CSR/MMIO block (master) and the divider (slave).
//   cfg_we_i  : single-cycle write strobe
//   cfg_ch_i  : target channel index
//   cfg_div_i : new half-period divisor
//   cfg_en_i  : new channel enable
//   cfg_err_o : registered one-cycle pulse on an out-of-range channel index
interface riscv_clk_div_multi_if #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned DIV_W = riscv_clk_pkg::DIV_W_DEF
) ();

   localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic             cfg_we_i;
   logic [CH_W-1:0]  cfg_ch_i;
   logic [DIV_W-1:0] cfg_div_i;
   logic             cfg_en_i;
   logic             cfg_err_o;

   modport master (
      output cfg_we_i, cfg_ch_i, cfg_div_i, cfg_en_i,
      input  cfg_err_o
   );

   modport slave (
      input  cfg_we_i, cfg_ch_i, cfg_div_i, cfg_en_i,
      output cfg_err_o
   );

endinterface : riscv_clk_div_multi_if

// File: rtl/riscv_clk_div_ch.sv
// One divider channel: half-period counter, output clock and rise flops,
// active and pending configuration registers.
//   clk_i, x_reset : source clock, async active-low reset
//   load_i         : capture cfg_div_i/cfg_en_i into the pending register
//   clk_o          : divided clock (registered)
//   rise_o         : high in the cycle clk_o went 0->1 (registered)
//   pending_o      : a captured config has not been applied yet
module riscv_clk_div_ch
   import riscv_clk_pkg::*;
#(
   parameter int unsigned DIV_W       = DIV_W_DEF,
   parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
   input  logic             clk_i,
   input  logic             x_reset,
   input  logic             load_i,
   input  logic [DIV_W-1:0] cfg_div_i,
   input  logic             cfg_en_i,
   output logic             clk_o,
   output logic             rise_o,
   output logic             pending_o
);

   localparam clk_cfg_t RST_CFG = '{div: DIV_W_DEF'(DEFAULT_DIV), en: 1'b1};

   clk_cfg_t         act_q, act_d;
   clk_cfg_t         pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             clk_q, clk_d;
   logic             rise_q, rise_d;

   // Next-state: count, toggle, and apply pending config only at 0->1 or while parked
   always_comb begin
      act_d      = act_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      cnt_d      = cnt_q;
      clk_d      = clk_q;
      rise_d     = 1'b0;

      if (!act_q.en) begin
         // Parked high; nothing to wait for, so a pending config lands right away
         cnt_d = '0;
         clk_d = 1'b1;
         if (pend_vld_q) begin
            act_d      = pend_q;
            pend_vld_d = 1'b0;
         end
      end else if (cnt_q == DIV_W'(act_q.div)) begin
         cnt_d = '0;
         clk_d = ~clk_q;
         if (!clk_q) begin
            rise_d = 1'b1;
            if (pend_vld_q) begin
               act_d      = pend_q;
               pend_vld_d = 1'b0;
            end
         end
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end

      // A write in a boundary cycle lands after the old pending value was consumed
      if (load_i) begin
         pend_d.div = DIV_W_DEF'(cfg_div_i);
         pend_d.en  = cfg_en_i;
         pend_vld_d = 1'b1;
      end
   end

   // State registers
   always_ff @(posedge clk_i or negedge x_reset) begin
      if (!x_reset) begin
         act_q      <= RST_CFG;
         pend_q     <= RST_CFG;
         pend_vld_q <= 1'b0;
         cnt_q      <= '0;
         clk_q      <= 1'b1;
         rise_q     <= 1'b0;
      end else begin
         act_q      <= act_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         cnt_q      <= cnt_d;
         clk_q      <= clk_d;
         rise_q     <= rise_d;
      end
   end

   assign clk_o     = clk_q;
   assign rise_o    = rise_q;
   assign pending_o = pend_vld_q;

endmodule : riscv_clk_div_ch

// File: rtl/riscv_clk_div_multi.sv
// Multi-channel run-time-programmable clock divider.
//   clk_i, x_reset : source clock, async active-low reset
//   cfg            : config write port (slave side)
//   pending_o      : per-channel unapplied-config flag
//   clk_o          : per-channel divided clock
//   rise_o         : per-channel 0->1 pulse
module riscv_clk_div_multi
   import riscv_clk_pkg::*;
#(
   parameter int unsigned NCH         = 4,
   parameter int unsigned DIV_W       = DIV_W_DEF,
   parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
   input  logic                  clk_i,
   input  logic                  x_reset,
   riscv_clk_div_multi_if.slave  cfg,
   output logic [NCH-1:0]        pending_o,
   output logic [NCH-1:0]        clk_o,
   output logic [NCH-1:0]        rise_o
);

   localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0] load_c;
   logic           ch_oob_c;
   logic           err_q;

   assign ch_oob_c = (32'(cfg.cfg_ch_i) >= NCH);

   // Error pulse for writes addressed past the last channel
   always_ff @(posedge clk_i or negedge x_reset) begin
      if (!x_reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= cfg.cfg_we_i && ch_oob_c;
      end
   end

   assign cfg.cfg_err_o = err_q;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign load_c[i] = cfg.cfg_we_i && (cfg.cfg_ch_i == CH_W'(i));

      riscv_clk_div_ch #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_i     (clk_i),
         .x_reset   (x_reset),
         .load_i    (load_c[i]),
         .cfg_div_i (cfg.cfg_div_i),
         .cfg_en_i  (cfg.cfg_en_i),
         .clk_o     (clk_o[i]),
         .rise_o    (rise_o[i]),
         .pending_o (pending_o[i])
      );
   end

endmodule : riscv_clk_div_multi

// File: tb/tb_riscv_clk_div_multi.sv
// Directed bench for riscv_clk_div_multi: a 4-channel instance carries the
// main scenarios, a 3-channel instance gives a reachable out-of-range index.
// k counts clk_i rising edges since reset release; outputs are sampled 1ns
// after each edge.
module tb_riscv_clk_div_multi;

   logic       clk_i = 1'b0;
   logic       x_reset = 1'b0;
   logic [3:0] pend_w, clko_w, rise_w;
   logic [2:0] pend3_w, clko3_w, rise3_w;

   int n_chk = 0;
   int n_err = 0;

   riscv_clk_div_multi_if #(.NCH(4), .DIV_W(8)) cfg_if ();
   riscv_clk_div_multi_if #(.NCH(3), .DIV_W(8)) cfg3_if ();

   riscv_clk_div_multi #(.NCH(4), .DIV_W(8), .DEFAULT_DIV(3)) u_dut (
      .clk_i     (clk_i),
      .x_reset   (x_reset),
      .cfg       (cfg_if),
      .pending_o (pend_w),
      .clk_o     (clko_w),
      .rise_o    (rise_w)
   );

   riscv_clk_div_multi #(.NCH(3), .DIV_W(8), .DEFAULT_DIV(3)) u_dut3 (
      .clk_i     (clk_i),
      .x_reset   (x_reset),
      .cfg       (cfg3_if),
      .pending_o (pend3_w),
      .clk_o     (clko3_w),
      .rise_o    (rise3_w)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Default divisor 3: 4 high, 4 low, rise every 8 edges
   function automatic logic dflt_clk(input int k);
      return (k % 8) < 4;
   endfunction

   function automatic logic dflt_rise(input int k);
      return (k > 0) && (k % 8 == 0);
   endfunction

   // Hand-derived per-channel waveforms for the scheduled writes below
   function automatic logic exp_clk(input int ch, input int k);
      case (ch)
         0:       return (k < 72) ? dflt_clk(k) : (((k - 72) % 6) < 3);
         1:       return (k < 24) ? dflt_clk(k) : (k % 2 == 0);
         2:       return (k < 40) ? dflt_clk(k) : (k < 45) ? 1'b1 : (((k - 45) % 4) < 2);
         default: return (k < 96) ? dflt_clk(k) : (((k - 96) % 4) < 2);
      endcase
   endfunction

   function automatic logic exp_rise(input int ch, input int k);
      case (ch)
         0:       return (k < 72) ? dflt_rise(k) : ((k - 72) % 6 == 0);
         1:       return (k < 24) ? dflt_rise(k) : (k % 2 == 0);
         2:       return (k < 40) ? dflt_rise(k) : (k < 45) ? (k == 40) : ((k > 45) && ((k - 45) % 4 == 0));
         default: return (k < 96) ? dflt_rise(k) : ((k - 96) % 4 == 0);
      endcase
   endfunction

   function automatic logic exp_pend(input int ch, input int k);
      case (ch)
         0:       return ((k >= 66) && (k < 72)) || (k >= 103);
         1:       return (k >= 18) && (k < 24);
         2:       return ((k >= 34) && (k < 40)) || (k == 44);
         default: return (k >= 88) && (k < 96);
      endcase
   endfunction

   task automatic wr(input logic [1:0] ch, input logic [7:0] div, input logic en);
      cfg_if.cfg_we_i  = 1'b1;
      cfg_if.cfg_ch_i  = ch;
      cfg_if.cfg_div_i = div;
      cfg_if.cfg_en_i  = en;
   endtask

   task automatic check_idle_state(input string tag);
      check({tag, " clk"},   32'(clko_w),  32'hF);
      check({tag, " rise"},  32'(rise_w),  32'h0);
      check({tag, " pend"},  32'(pend_w),  32'h0);
      check({tag, " err"},   32'(cfg_if.cfg_err_o), 32'h0);
      check({tag, " clk3"},  32'(clko3_w), 32'h7);
      check({tag, " pend3"}, 32'(pend3_w), 32'h0);
      check({tag, " err3"},  32'(cfg3_if.cfg_err_o), 32'h0);
   endtask

   task automatic check_default(input int k);
      logic d_clk, d_rise;
      d_clk  = dflt_clk(k);
      d_rise = dflt_rise(k);
      check($sformatf("dflt clk k=%0d", k),   32'(clko_w),  32'({4{d_clk}}));
      check($sformatf("dflt rise k=%0d", k),  32'(rise_w),  32'({4{d_rise}}));
      check($sformatf("dflt pend k=%0d", k),  32'(pend_w),  32'h0);
      check($sformatf("dflt clk3 k=%0d", k),  32'(clko3_w), 32'({3{d_clk}}));
      check($sformatf("dflt rise3 k=%0d", k), 32'(rise3_w), 32'({3{d_rise}}));
   endtask

   initial begin
      logic [3:0] e_clk, e_rise, e_pend;

      cfg_if.cfg_we_i   = 1'b0;
      cfg_if.cfg_ch_i   = '0;
      cfg_if.cfg_div_i  = '0;
      cfg_if.cfg_en_i   = 1'b0;
      cfg3_if.cfg_we_i  = 1'b0;
      cfg3_if.cfg_ch_i  = '0;
      cfg3_if.cfg_div_i = '0;
      cfg3_if.cfg_en_i  = 1'b0;

      #12;
      check_idle_state("reset");
      @(negedge clk_i);
      x_reset = 1'b1;
      #1;
      check_idle_state("release");

      // Main run: channel-specific writes interleaved with per-edge checks
      for (int k = 1; k <= 105; k++) begin
         tick();
         for (int c = 0; c < 4; c++) begin
            e_clk[c]  = exp_clk(c, k);
            e_rise[c] = exp_rise(c, k);
            e_pend[c] = exp_pend(c, k);
         end
         check($sformatf("clk k=%0d", k),   32'(clko_w), 32'(e_clk));
         check($sformatf("rise k=%0d", k),  32'(rise_w), 32'(e_rise));
         check($sformatf("pend k=%0d", k),  32'(pend_w), 32'(e_pend));
         check($sformatf("err k=%0d", k),   32'(cfg_if.cfg_err_o), 32'h0);
         check($sformatf("clk3 k=%0d", k),  32'(clko3_w), 32'({3{dflt_clk(k)}}));
         check($sformatf("pend3 k=%0d", k), 32'(pend3_w), 32'h0);
         check($sformatf("err3 k=%0d", k),  32'(cfg3_if.cfg_err_o), 32'(k == 80));

         // Drive the write captured on edge k+1
         cfg_if.cfg_we_i  = 1'b0;
         cfg3_if.cfg_we_i = 1'b0;
         case (k + 1)
            18:  wr(2'd1, 8'd0, 1'b1);
            34:  wr(2'd2, 8'd3, 1'b0);
            44:  wr(2'd2, 8'd1, 1'b1);
            66:  wr(2'd0, 8'd5, 1'b1);
            68:  wr(2'd0, 8'd2, 1'b1);
            88:  wr(2'd3, 8'd1, 1'b1);
            103: wr(2'd0, 8'd4, 1'b1);
            80: begin
               cfg3_if.cfg_we_i  = 1'b1;
               cfg3_if.cfg_ch_i  = 2'd3;
               cfg3_if.cfg_div_i = 8'd0;
               cfg3_if.cfg_en_i  = 1'b1;
            end
            default: ;
         endcase
      end

      // Async reset mid-low-phase of ch0 with its pending config set
      #1;
      x_reset = 1'b0;
      #1;
      check_idle_state("async rst");
      tick();
      tick();
      check_idle_state("held rst");
      @(negedge clk_i);
      x_reset = 1'b1;
      #1;
      check_idle_state("re-release");
      for (int k = 1; k <= 20; k++) begin
         tick();
         check_default(k);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_riscv_clk_div_multi
